// File: rtl/axi_write_buffer.sv
// rtl/axi_write_buffer.sv - posted-write FIFO draining single-word stores as single-beat AXI bursts
//
// Purpose: accepts one store per cycle from the data cache and replays each one
// to AXI as an AW + one W beat + B. Also provides a combinational address-conflict
// check for younger reads and an empty flag for synchronisation points.
//
// Build option: define AXI_WB_MERGE_EN to merge a store into the youngest entry
// when both fall in the same 32-bit word.
//
// Ports:
//   aclk, aresetn                  clock, asynchronous active-low reset
//   push_valid/ready/addr/size/data/strb   store request from the data cache
//   chk_addr, chk_hit              word-granular conflict lookup
//   empty                          no entries and no AXI transaction outstanding
//   aw*, w*, b*                    AXI write address, data and response channels
module axi_write_buffer #(
  parameter int         DEPTH  = 4,
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        push_valid,
  output logic        push_ready,
  input  logic [31:0] push_addr,
  input  logic [1:0]  push_size,
  input  logic [31:0] push_data,
  input  logic [3:0]  push_strb,
  input  logic [31:0] chk_addr,
  output logic        chk_hit,
  output logic        empty,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_B} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [31:0]    r_addr [DEPTH];
  logic [1:0]     r_size [DEPTH];
  logic [31:0]    r_data [DEPTH];
  logic [3:0]     r_strb [DEPTH];
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  logic           r_aw_done;
  logic           r_w_done;

  logic           w_full;
  logic           w_merge_ok;
  logic           w_push_fire;
  logic           w_alloc;
  logic           w_pop;
  logic           w_aw_hs;
  logic           w_w_hs;
  logic [PW-1:0]  w_off;
  logic           w_unused;

  // The response ID/status and the byte offset of the lookup address carry no information here.
  assign w_unused = ^{bid, bresp, chk_addr[1:0]};

  assign w_full = (r_count == CW'(DEPTH));

`ifdef AXI_WB_MERGE_EN
  logic [PW-1:0] w_tail_m1;
  assign w_tail_m1 = r_tail - PW'(1);
  // The youngest entry may only be merged into if it is not the head already on the bus.
  assign w_merge_ok = (r_count != '0) && (r_addr[w_tail_m1][31:2] == push_addr[31:2]) &&
                      ((r_count >= CW'(2)) || (r_state == S_IDLE));
`else
  assign w_merge_ok = 1'b0;
`endif

  assign push_ready  = !w_full || w_merge_ok;
  assign w_push_fire = push_valid && push_ready;
  assign w_alloc     = w_push_fire && !w_merge_ok;
  assign w_pop       = (r_state == S_WAIT_B) && bvalid;
  assign w_aw_hs     = awvalid && awready;
  assign w_w_hs      = wvalid && wready;

  assign empty = (r_count == '0) && (r_state == S_IDLE);

  // Drain FSM; a push into an idle buffer starts the transaction on the very next cycle.
  always_comb begin
    w_state_nxt = r_state;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    bready      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_count != '0) || w_alloc) w_state_nxt = S_SEND;
      end
      S_SEND: begin
        awvalid = !r_aw_done;
        wvalid  = !r_w_done;
        if ((r_aw_done || awready) && (r_w_done || wready)) w_state_nxt = S_WAIT_B;
      end
      S_WAIT_B: begin
        bready = 1'b1;
        if (bvalid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // AW and W complete independently; each flag remembers its own handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (r_state != S_SEND) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc) r_tail <= r_tail + PW'(1);
      if (w_pop)   r_head <= r_head + PW'(1);
      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_size[i] <= '0;
        r_data[i] <= '0;
        r_strb[i] <= '0;
      end
    end else begin
      if (w_alloc) begin
        r_addr[r_tail] <= push_addr;
        r_size[r_tail] <= push_size;
        r_data[r_tail] <= push_data;
        r_strb[r_tail] <= push_strb;
      end
`ifdef AXI_WB_MERGE_EN
      if (w_push_fire && w_merge_ok) begin
        r_strb[w_tail_m1]      <= r_strb[w_tail_m1] | push_strb;
        r_size[w_tail_m1]      <= 2'd2;
        r_addr[w_tail_m1][1:0] <= 2'b00;
        for (int b = 0; b < 4; b++) begin
          if (push_strb[b]) r_data[w_tail_m1][8*b +: 8] <= push_data[8*b +: 8];
        end
      end
`endif
    end
  end

  // Conflict lookup over the occupied window head..tail-1, including the head in flight.
  always_comb begin
    chk_hit = 1'b0;
    w_off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_head;
      if (({1'b0, w_off} < r_count) && (r_addr[i][31:2] == chk_addr[31:2])) chk_hit = 1'b1;
    end
  end

  assign awid    = AXI_ID;
  assign awaddr  = r_addr[r_head];
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, r_size[r_head]};
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign wid     = AXI_ID;
  assign wdata   = r_data[r_head];
  assign wstrb   = r_strb[r_head];
  assign wlast   = 1'b1;

endmodule
